// File: rtl/parking_pkg.sv
// Shared types for the parking-lot controller: gate FSM states and the
// debounced {a,b} sensor patterns a car produces while crossing a gate.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EN1,
      EN2,
      EN3,
      EX1,
      EX2,
      EX3
   } gate_state_t;

   localparam logic [1:0] P_NONE = 2'b00;
   localparam logic [1:0] P_OUT  = 2'b10;
   localparam logic [1:0] P_BOTH = 2'b11;
   localparam logic [1:0] P_IN   = 2'b01;

endpackage

// File: rtl/gate_decoder.sv
// One gate: synchronise and debounce the outer/inner sensors, then decode
// the car direction into registered one-cycle enter/exit pulses.
module gate_decoder
   import parking_pkg::*;
#(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic enter,
   output logic exit
);

   localparam int CW = $clog2(DB_CYCLES);

   logic [1:0]    raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [CW-1:0] cnt [2];

   gate_state_t state;
   gate_state_t state_next;
   logic        enter_next;
   logic        exit_next;

   assign raw = {a, b};

   // Any sample equal to the accepted level restarts the stability window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      enter_next = 1'b0;
      exit_next  = 1'b0;
      case (state)
         IDLE: begin
            if (deb == P_OUT)     state_next = EN1;
            else if (deb == P_IN) state_next = EX1;
         end
         EN1: begin
            if (deb == P_BOTH)     state_next = EN2;
            else if (deb != P_OUT) state_next = IDLE;
         end
         EN2: begin
            if (deb == P_IN)       state_next = EN3;
            else if (deb == P_OUT) state_next = EN1;
            else if (deb != P_BOTH) state_next = IDLE;
         end
         EN3: begin
            if (deb == P_BOTH) state_next = EN2;
            else if (deb != P_IN) begin
               state_next = IDLE;
               enter_next = (deb == P_NONE);
            end
         end
         EX1: begin
            if (deb == P_BOTH)    state_next = EX2;
            else if (deb != P_IN) state_next = IDLE;
         end
         EX2: begin
            if (deb == P_OUT)       state_next = EX3;
            else if (deb == P_IN)   state_next = EX1;
            else if (deb != P_BOTH) state_next = IDLE;
         end
         EX3: begin
            if (deb == P_BOTH) state_next = EX2;
            else if (deb != P_OUT) begin
               state_next = IDLE;
               exit_next  = (deb == P_NONE);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         enter <= 1'b0;
         exit  <= 1'b0;
      end else begin
         state <= state_next;
         enter <= enter_next;
         exit  <= exit_next;
      end
   end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-gate occupancy controller: per-gate direction decoders feeding a
// saturating occupancy counter with registered full/empty flags.
module parking_lot_ctrl #(
   parameter int N_GATES   = 2,
   parameter int CAPACITY  = 99,
   parameter int DB_CYCLES = 500000,
   parameter int COUNT_W   = $clog2(CAPACITY + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_GATES-1:0] a,
   input  logic [N_GATES-1:0] b,
   output logic [COUNT_W-1:0] count,
   output logic               full,
   output logic               empty,
   output logic [N_GATES-1:0] enter,
   output logic [N_GATES-1:0] exit,
   output logic               overflow,
   output logic               underflow
);

   // Headroom for count + up to 8 entries, plus a sign bit.
   localparam int SUM_W = COUNT_W + 5;
   localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

   logic [3:0]               n_enter;
   logic [3:0]               n_exit;
   logic signed [SUM_W-1:0]  next_sum;
   logic [COUNT_W-1:0]       count_next;
   logic                     ovf_next;
   logic                     unf_next;

   for (genvar g = 0; g < N_GATES; g++) begin : g_gate
      gate_decoder #(
         .DB_CYCLES (DB_CYCLES)
      ) u_dec (
         .clk   (clk),
         .reset (reset),
         .a     (a[g]),
         .b     (b[g]),
         .enter (enter[g]),
         .exit  (exit[g])
      );
   end

   // Entries and exits net out before clamping.
   always_comb begin
      n_enter = '0;
      n_exit  = '0;
      for (int i = 0; i < N_GATES; i++) begin
         n_enter = n_enter + 4'(enter[i]);
         n_exit  = n_exit + 4'(exit[i]);
      end
      next_sum   = SUM_W'(count) + SUM_W'(n_enter) - SUM_W'(n_exit);
      count_next = next_sum[COUNT_W-1:0];
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
      if (next_sum[SUM_W-1]) begin
         count_next = '0;
         unf_next   = 1'b1;
      end else if (next_sum > CAP_S) begin
         count_next = COUNT_W'(CAPACITY);
         ovf_next   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count_next;
         full      <= (count_next == COUNT_W'(CAPACITY));
         empty     <= (count_next == '0);
         overflow  <= ovf_next;
         underflow <= unf_next;
      end
   end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl with two gates, capacity 3 and a
// four-cycle debounce window.
module tb_parking_lot_ctrl;
   import parking_pkg::*;

   localparam int N  = 2;
   localparam int CP = 3;
   localparam int DB = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [N-1:0]  enter;
   logic [N-1:0]  exit;
   logic          overflow;
   logic          underflow;

   int n_cmp  = 0;
   int n_fail = 0;
   int tot_enter [2] = '{0, 0};
   int tot_exit  [2] = '{0, 0};
   int tot_over  = 0;
   int tot_under = 0;

   always #5 clk = ~clk;

   parking_lot_ctrl #(
      .N_GATES   (N),
      .CAPACITY  (CP),
      .DB_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .enter     (enter),
      .exit      (exit),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Pulse tallies, sampled before the edge updates the outputs.
   always @(posedge clk) begin
      for (int g = 0; g < N; g++) begin
         tot_enter[g] += int'(enter[g]);
         tot_exit[g]  += int'(exit[g]);
      end
      tot_over  += int'(overflow);
      tot_under += int'(underflow);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_gate(input int g, input logic [1:0] p);
      a[g] = p[1];
      b[g] = p[0];
   endtask

   task automatic car(input int g, input bit entering);
      if (entering) begin
         set_gate(g, P_OUT);  step(10);
         set_gate(g, P_BOTH); step(10);
         set_gate(g, P_IN);   step(10);
      end else begin
         set_gate(g, P_IN);   step(10);
         set_gate(g, P_BOTH); step(10);
         set_gate(g, P_OUT);  step(10);
      end
      set_gate(g, P_NONE); step(10);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      a = '0;
      b = '0;
      step(3);
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_cmp++; if ({enter, exit, overflow, underflow} !== 6'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 000000", {enter, exit, overflow, underflow}); end
      reset = 1'b1;
      step(2);
      set_gate(0, P_OUT);  step(10);
      set_gate(0, P_BOTH); step(10);
      reset = 1'b0;
      step(1);
      n_cmp++; if ({count, full, empty} !== 4'b0001) begin n_fail++; $display("FAIL midreset_flags: got %b want 0001", {count, full, empty}); end
      step(2);
      reset = 1'b1;
      step(10);
      set_gate(0, P_NONE); step(10);
      n_cmp++; if (tot_enter[0] + tot_exit[0] !== 0) begin n_fail++; $display("FAIL midreset_lost: got %0d pulses want 0", tot_enter[0] + tot_exit[0]); end
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
   endtask

   task automatic test_clean_entry_exit();
      int e0;
      int x1;
      e0 = tot_enter[0];
      x1 = tot_exit[1];
      set_gate(0, P_OUT);  step(10);
      set_gate(0, P_BOTH); step(10);
      set_gate(0, P_IN);   step(10);
      set_gate(0, P_NONE); step(7);
      n_cmp++; if (enter !== 2'b01) begin n_fail++; $display("FAIL entry_pulse_time: got %b want 01", enter); end
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL entry_count_early: got %0d want 0", count); end
      step(1);
      n_cmp++; if (enter !== 2'b00) begin n_fail++; $display("FAIL entry_pulse_width: got %b want 00", enter); end
      n_cmp++; if ({count, full, empty} !== 4'b0100) begin n_fail++; $display("FAIL entry_count: got %b want 0100", {count, full, empty}); end
      step(2);
      n_cmp++; if (tot_enter[0] - e0 !== 1) begin n_fail++; $display("FAIL entry_pulses: got %0d want 1", tot_enter[0] - e0); end
      car(1, 1'b0);
      n_cmp++; if (tot_exit[1] - x1 !== 1) begin n_fail++; $display("FAIL exit_pulses: got %0d want 1", tot_exit[1] - x1); end
      n_cmp++; if ({count, empty} !== 3'b001) begin n_fail++; $display("FAIL exit_count: got %b want 001", {count, empty}); end
   endtask

   task automatic test_abort_bounce();
      int e0;
      int x0;
      e0 = tot_enter[0];
      x0 = tot_exit[0];
      set_gate(0, P_OUT);  step(10);
      set_gate(0, P_BOTH); step(10);
      set_gate(0, P_OUT);  step(10);
      set_gate(0, P_NONE); step(10);
      n_cmp++; if (tot_enter[0] - e0 + tot_exit[0] - x0 !== 0) begin n_fail++; $display("FAIL backout_pulses: got %0d want 0", tot_enter[0] - e0 + tot_exit[0] - x0); end
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL backout_count: got %0d want 0", count); end
      car(0, 1'b1);
      x0 = tot_exit[0];
      set_gate(0, P_IN);   step(10);
      set_gate(0, P_BOTH); step(10);
      set_gate(0, P_OUT);  step(10);
      // Short drops of the outer beam while parked in EX3 must not complete the exit.
      for (int k = 0; k < 3; k++) begin
         a[0] = 1'b0; step(2);
         a[0] = 1'b1; step(8);
      end
      n_cmp++; if (tot_exit[0] - x0 !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", tot_exit[0] - x0); end
      n_cmp++; if (count !== 2'd1) begin n_fail++; $display("FAIL glitch_count: got %0d want 1", count); end
      set_gate(0, P_NONE); step(10);
      n_cmp++; if (tot_exit[0] - x0 !== 1) begin n_fail++; $display("FAIL glitch_then_exit: got %0d want 1", tot_exit[0] - x0); end
      n_cmp++; if (count !== 2'd0) begin n_fail++; $display("FAIL glitch_final_count: got %0d want 0", count); end
   endtask

   task automatic test_saturation();
      int ov;
      int un;
      for (int k = 0; k < 3; k++) car(0, 1'b1);
      n_cmp++; if ({count, full, empty} !== 4'b1110) begin n_fail++; $display("FAIL sat_full: got %b want 1110", {count, full, empty}); end
      ov = tot_over;
      car(0, 1'b1);
      n_cmp++; if ({count, full} !== 3'b111) begin n_fail++; $display("FAIL sat_hold: got %b want 111", {count, full}); end
      n_cmp++; if (tot_over - ov !== 1) begin n_fail++; $display("FAIL sat_overflow: got %0d want 1", tot_over - ov); end
      for (int k = 0; k < 3; k++) car(1, 1'b0);
      n_cmp++; if ({count, empty} !== 3'b001) begin n_fail++; $display("FAIL sat_drain: got %b want 001", {count, empty}); end
      un = tot_under;
      car(1, 1'b0);
      n_cmp++; if ({count, empty} !== 3'b001) begin n_fail++; $display("FAIL sat_zero_hold: got %b want 001", {count, empty}); end
      n_cmp++; if (tot_under - un !== 1) begin n_fail++; $display("FAIL sat_underflow: got %0d want 1", tot_under - un); end
   endtask

   task automatic test_simultaneous();
      int ov;
      int un;
      for (int k = 0; k < 3; k++) car(0, 1'b1);
      n_cmp++; if (count !== 2'd3) begin n_fail++; $display("FAIL sim_setup: got %0d want 3", count); end
      ov = tot_over;
      set_gate(0, P_OUT);  set_gate(1, P_IN);  step(10);
      set_gate(0, P_BOTH); set_gate(1, P_BOTH); step(10);
      set_gate(0, P_IN);   set_gate(1, P_OUT); step(10);
      set_gate(0, P_NONE); set_gate(1, P_NONE); step(7);
      n_cmp++; if ({enter, exit} !== 4'b0110) begin n_fail++; $display("FAIL sim_pulses: got %b want 0110", {enter, exit}); end
      step(3);
      n_cmp++; if ({count, full} !== 3'b111) begin n_fail++; $display("FAIL sim_net_count: got %b want 111", {count, full}); end
      n_cmp++; if (tot_over - ov !== 0) begin n_fail++; $display("FAIL sim_no_overflow: got %0d want 0", tot_over - ov); end
      car(1, 1'b0);
      car(1, 1'b0);
      n_cmp++; if (count !== 2'd1) begin n_fail++; $display("FAIL sim_count_one: got %0d want 1", count); end
      un = tot_under;
      set_gate(0, P_IN);   set_gate(1, P_IN);   step(10);
      set_gate(0, P_BOTH); set_gate(1, P_BOTH); step(10);
      set_gate(0, P_OUT);  set_gate(1, P_OUT);  step(10);
      set_gate(0, P_NONE); set_gate(1, P_NONE); step(7);
      n_cmp++; if (exit !== 2'b11) begin n_fail++; $display("FAIL sim_double_exit: got %b want 11", exit); end
      step(1);
      n_cmp++; if ({count, underflow} !== 3'b001) begin n_fail++; $display("FAIL sim_underflow_now: got %b want 001", {count, underflow}); end
      step(2);
      n_cmp++; if (tot_under - un !== 1) begin n_fail++; $display("FAIL sim_underflow_count: got %0d want 1", tot_under - un); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sim_empty: got %b want 1", empty); end
   endtask

   initial begin
      test_reset();
      test_clean_entry_exit();
      test_abort_bounce();
      test_saturation();
      test_simultaneous();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Multi-gate parking-lot occupancy controller, the parametrised successor of the two-sensor single-gate counter. Each of `N_GATES` gates has an outer sensor `a` and an inner sensor `b`. The block synchronises and debounces every sensor and decodes car direction with a per-gate state machine. It keeps a saturating occupancy count bounded by `CAPACITY` and reports full/empty status. Its count output feeds the existing hex display path at top level.

## Interface
- `N_GATES`, 2, number of gates (1..8).
- `CAPACITY`, 99, maximum occupancy (1..255).
- `DB_CYCLES`, 500000, consecutive stable cycles required to accept a sensor level (≥2).
- `COUNT_W`, `$clog2(CAPACITY+1)`, derived count width; not overridden.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset. Deassertion is synchronised externally.
- `a` in N_GATES: raw outer sensors, asynchronous, 1 = beam blocked.
- `b` in N_GATES: raw inner sensors, asynchronous, 1 = beam blocked.
- `count` out COUNT_W: current occupancy, registered.
- `full` out 1: `count == CAPACITY`, registered.
- `empty` out 1: `count == 0`, registered.
- `enter` out N_GATES: one-cycle pulse per gate on a completed entry.
- `exit` out N_GATES: one-cycle pulse per gate on a completed exit.
- `overflow` out 1: one-cycle pulse when entries were dropped at capacity.
- `underflow` out 1: one-cycle pulse when exits were dropped at zero.

## Operation
- **Input conditioning:** each raw sensor goes through a 2-FF synchroniser, then a debouncer. The debouncer has a counter that clears on any change of the synchronised level. The debounced output takes the new level only after `DB_CYCLES` consecutive equal samples. Its reset value is 0.
- **Gate state machine:** the input is the debounced pattern {a,b}. States are IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
  - Entry path: IDLE -10-> EN1 -11-> EN2 -01-> EN3 -00-> IDLE, pulsing `enter`.
  - Exit path: IDLE -01-> EX1 -11-> EX2 -10-> EX3 -00-> IDLE, pulsing `exit`.
  - Pattern equal to the state's own pattern: hold.
  - Pattern equal to the previous step's pattern: step back one state (EN1/EX1 back to IDLE on 00). A car reversing mid-gate therefore produces no count.
  - Any other pattern, including 00 anywhere except EN3/EX3: go to IDLE with no pulse.
  - IDLE on 11: stay in IDLE.
- **Occupancy update:** each cycle, E = popcount(`enter`) and X = popcount(`exit`), computed in a width that cannot overflow.
  - next = count + E − X, evaluated signed.
  - If next > CAPACITY: count = CAPACITY and pulse `overflow`.
  - If next < 0: count = 0 and pulse `underflow`.
  - Simultaneous entries and exits on different gates net out before clamping. Example: full, one enter plus one exit gives count unchanged and no overflow.
  - `full` and `empty` are registered from the next count, so they are always coherent with `count`.
- **Reset:** `reset` low forces all of the following to 0/IDLE immediately:
  - synchronisers, debouncers and FSMs;
  - `count`, `enter`, `exit`, `overflow` and `underflow`;
  - `empty` = 1 and `full` = 0.
  
  A car in progress at reset is lost, not counted.

## Timing
- Raw edge to debounced level change: 2 + `DB_CYCLES` cycles.
- Debounced 00 in EN3/EX3 to `enter`/`exit` pulse: 1 cycle (registered FSM output).
- Pulse to `count`/`full`/`empty`/`overflow`/`underflow` update: 1 cycle.
- Raw final sensor release to count change: 2 + `DB_CYCLES` + 2 cycles.
- A glitch shorter than `DB_CYCLES` cycles produces no state change.
- Pulses are exactly one cycle wide. A gate cannot pulse on consecutive cycles, because a new sequence needs at least four debounced changes.

## Structure
- Package `parking_pkg` holds:
  - the `gate_state_t` enum (IDLE, EN1, EN2, EN3, EX1, EX2, EX3);
  - the sensor pattern constants `P_NONE = 2'b00`, `P_OUT = 2'b10`, `P_BOTH = 2'b11`, `P_IN = 2'b01`.
- Sub-module `gate_decoder`: one gate's two synchronisers, two debouncers and the direction FSM. It outputs `enter` and `exit` pulses and is instantiated `N_GATES` times in a generate loop.
- The top level holds the popcount, the saturating counter and the flags.

## Test plan
Bench parameters: `N_GATES`=2, `CAPACITY`=3, `DB_CYCLES`=4.
- **Reset:** hold `reset`=0 mid-sequence, then release. Required: count=0, empty=1, full=0, all pulses 0, and gate 0 in IDLE on the next 00.
- **Clean entry and exit:** gate 0 steps 00,10,11,01,00, each held 10 cycles. Required: one `enter[0]` pulse and count 0→1 exactly 2+4+2 cycles after the final release. Gate 1 then steps 00,01,11,10,00. Required: one `exit[1]` pulse and count back to 0.
- **Aborted and bounced sequences:**
  - Gate 0 steps 10,11,10,00 (car backs out). Required: no pulse, count unchanged.
  - 2-cycle pulses on `a`. Required: no state change.
- **Saturation:** drive 3 entries so count=3 and full=1, then a 4th entry. Required: count stays 3 with one `overflow` pulse. From empty, an exit gives count 0 with one `underflow` pulse.
- **Simultaneous gates:** at count=3, complete an entry on gate 0 and an exit on gate 1 with final releases on the same cycle. Required: count stays 3 with no overflow. At count=1, two simultaneous exits. Required: count 0 and an `underflow` pulse.
